ps2_scancode_rx: RTL and testbench

PS/2 device-to-host receiver that turns the raw keyboard `kclock`/`kdata` lines into validated scan-code events. It handles synchronisation, 11-bit frame capture, odd-parity and framing checks, inactivity timeout, and folding of `E0` (extended) and `F0` (break) prefixes. It sits directly upstream of the VGA colour/paint logic, which consumes one `code_valid` strobe per key event instead of raw shift-register taps.

---
 rtl/ps2_scancode_rx.sv | 131 +++++++++++++
 tb/tb_ps2_scancode_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronises kclock/kdata, captures 11-bit frames,
// checks start/parity/stop and timeout, and folds E0/F0 prefixes into one event.
module ps2_scancode_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclock,
  input  logic       kdata,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       err_parity,
  output logic       err_frame,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        ks1, ks2, ks3;
  logic        ds1, ds2;
  logic        fall;
  logic        timeout;
  logic [7:0]  sh;
  logic        p;
  logic [2:0]  bitcnt;
  logic [15:0] tcnt;
  logic        brk_pend, ext_pend;

  assign fall    = ks3 & ~ks2;
  assign timeout = (state != IDLE) && (tcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ks1         <= 1'b0;
      ks2         <= 1'b0;
      ks3         <= 1'b0;
      ds1         <= 1'b0;
      ds2         <= 1'b0;
      sh          <= '0;
      p           <= 1'b0;
      bitcnt      <= '0;
      tcnt        <= '0;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
      code        <= '0;
      code_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ks1 <= kclock;
      ks2 <= ks1;
      ks3 <= ks2;
      ds1 <= kdata;
      ds2 <= ds1;

      code_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;

      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 16'd1;

      // Timeout has priority: a fall arriving in the same cycle is dropped.
      if (timeout) begin
        state     <= IDLE;
        busy      <= 1'b0;
        err_frame <= 1'b1;
        brk_pend  <= 1'b0;
        ext_pend  <= 1'b0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!ds2) begin
              state  <= DATA;
              bitcnt <= '0;
              busy   <= 1'b1;
            end else begin
              err_frame <= 1'b1;
              brk_pend  <= 1'b0;
              ext_pend  <= 1'b0;
            end
          end
          DATA: begin
            sh     <= {ds2, sh[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            p     <= ds2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!ds2) begin
              err_frame <= 1'b1;
              brk_pend  <= 1'b0;
              ext_pend  <= 1'b0;
            end else if (^{sh, p} == 1'b0) begin
              err_parity <= 1'b1;
              brk_pend   <= 1'b0;
              ext_pend   <= 1'b0;
            end else if (sh == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (sh == 8'hE0) begin
              ext_pend <= 1'b1;
            end else begin
              code        <= sh;
              is_break    <= brk_pend;
              is_extended <= ext_pend;
              code_valid  <= 1'b1;
              brk_pend    <= 1'b0;
              ext_pend    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: table of directed frames, hand-written
// timeout/reset sequences, then random frames against a frame-level reference model.
module tb_ps2_scancode_rx;

  localparam int TO   = 200;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       rst, kclock, kdata;
  logic [7:0] code;
  logic       code_valid, is_break, is_extended, err_parity, err_frame, busy;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .kclock(kclock), .kdata(kdata),
    .code(code), .code_valid(code_valid), .is_break(is_break),
    .is_extended(is_extended), .err_parity(err_parity),
    .err_frame(err_frame), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  always @(posedge clk) cyc++;

  // Event kinds: 0 none, 1 code_valid, 2 err_parity, 3 err_frame
  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    int         cyc;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [7:0] d;
    logic       bp, bs, bst;
    int         kind;
    logic [7:0] ecode;
    logic       ebrk, eext;
  } vec_t;

  // Reference state: pending prefixes and the held event fields
  logic       m_brk = 1'b0, m_ext = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic       m_isb = 1'b0, m_ise = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (code_valid || err_parity || err_frame)) begin
      ev_t e;
      chk($countones({code_valid, err_parity, err_frame}) == 1, "strobe_onehot",
          {code_valid, err_parity, err_frame}, 1);
      e.kind = code_valid ? 1 : (err_parity ? 2 : 3);
      e.code = code;
      e.brk  = is_break;
      e.ext  = is_extended;
      e.cyc  = cyc;
      evq.push_back(e);
    end
  end

  task automatic send_bit(input logic b);
    kdata = b;
    repeat (HALF) @(negedge clk);
    kclock    = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    kclock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bp, input logic bs, input logic bst);
    if (bs) begin
      send_bit(1'b1);
    end else begin
      send_bit(1'b0);
      for (int unsigned i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((~^d) ^ bp);
      send_bit(~bst);
    end
    kdata = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Frame-level rules: bad start/stop -> framing error, wrong odd parity ->
  // parity error, F0/E0 arm prefixes, anything else is a key event.
  task automatic model(input logic [7:0] d, input logic bp, input logic bs,
                       input logic bst, output int kind);
    if (bs || bst)        kind = 3;
    else if (bp)          kind = 2;
    else if (d == 8'hF0)  begin kind = 0; m_brk = 1'b1; end
    else if (d == 8'hE0)  begin kind = 0; m_ext = 1'b1; end
    else begin
      kind   = 1;
      m_code = d;
      m_isb  = m_brk;
      m_ise  = m_ext;
    end
    if (kind != 0) begin m_brk = 1'b0; m_ext = 1'b0; end
  endtask

  task automatic check_events(input string tag, input int kind, input logic [7:0] ecode,
                              input logic ebrk, input logic eext);
    chk(evq.size() == (kind == 0 ? 0 : 1), {tag, "_evcount"}, evq.size(), kind == 0 ? 0 : 1);
    if (kind != 0 && evq.size() > 0) begin
      chk(evq[0].kind == kind, {tag, "_kind"}, evq[0].kind, kind);
      if (kind == 1) begin
        chk(evq[0].code == ecode, {tag, "_code"}, evq[0].code, ecode);
        chk(evq[0].brk == ebrk, {tag, "_brk"}, evq[0].brk, ebrk);
        chk(evq[0].ext == eext, {tag, "_ext"}, evq[0].ext, eext);
      end
    end
    evq.delete();
    chk({code, is_break, is_extended} == {m_code, m_isb, m_ise}, {tag, "_held"},
        {code, is_break, is_extended}, {m_code, m_isb, m_ise});
    chk(busy == 1'b0, {tag, "_busy_idle"}, busy, 0);
  endtask

  vec_t tbl[$];

  initial begin
    int kind;
    rst = 1'b0; kclock = 1'b1; kdata = 1'b1;
    repeat (3) @(negedge clk);
    chk({code, code_valid, is_break, is_extended, err_parity, err_frame, busy} == '0,
        "reset_outputs", {code, code_valid, is_break, is_extended, err_parity, err_frame, busy}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    //              d      bp    bs    bst   kind code   brk   ext
    tbl.push_back('{8'h2D, 1'b0, 1'b0, 1'b0, 1, 8'h2D, 1'b0, 1'b0});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'h2D, 1'b0, 1'b0, 1'b0, 1, 8'h2D, 1'b1, 1'b0});
    tbl.push_back('{8'hE0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'h75, 1'b0, 1'b0, 1'b0, 1, 8'h75, 1'b1, 1'b1});
    tbl.push_back('{8'h1C, 1'b0, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0});
    tbl.push_back('{8'h2D, 1'b1, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'h2D, 1'b1, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'h2D, 1'b0, 1'b0, 1'b0, 1, 8'h2D, 1'b0, 1'b0});
    tbl.push_back('{8'hE0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'h2D, 1'b0, 1'b0, 1'b1, 3, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'h1C, 1'b0, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 1, 8'h5A, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      send_frame(tbl[i].d, tbl[i].bp, tbl[i].bs, tbl[i].bst);
      model(tbl[i].d, tbl[i].bp, tbl[i].bs, tbl[i].bst, kind);
      check_events($sformatf("tbl%0d", i), tbl[i].kind, tbl[i].ecode, tbl[i].ebrk, tbl[i].eext);
    end

    // Timeout: F0 armed, then start + 5 data bits and kclock parked high
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    model(8'hF0, 1'b0, 1'b0, 1'b0, kind);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 5; i++) send_bit(i[0]);
    repeat (5) @(negedge clk);
    chk(busy == 1'b1, "to_busy_mid", busy, 1);
    repeat (TO + 20) @(negedge clk);
    chk(evq.size() == 1, "to_evcount", evq.size(), 1);
    if (evq.size() > 0) begin
      chk(evq[0].kind == 3, "to_kind", evq[0].kind, 3);
      chk(evq[0].cyc - last_fall >= TO + 1 && evq[0].cyc - last_fall <= TO + 5,
          "to_latency", evq[0].cyc - last_fall, TO + 3);
    end
    evq.delete();
    m_brk = 1'b0; m_ext = 1'b0;
    chk(busy == 1'b0, "to_busy_after", busy, 0);
    send_frame(8'h2D, 1'b0, 1'b0, 1'b0);
    model(8'h2D, 1'b0, 1'b0, 1'b0, kind);
    check_events("to_recover", 1, 8'h2D, 1'b0, 1'b0);

    // Reset mid-frame after arming F0: outputs clear, prefix forgotten
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    model(8'hF0, 1'b0, 1'b0, 1'b0, kind);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk({code, code_valid, is_break, is_extended, err_parity, err_frame, busy} == '0,
        "rst_mid_outputs", {code, code_valid, is_break, is_extended, err_parity, err_frame, busy}, 0);
    repeat (HALF * 4) @(negedge clk);
    m_brk = 1'b0; m_ext = 1'b0; m_code = 8'h00; m_isb = 1'b0; m_ise = 1'b0;
    check_events("rst_mid", 0, 8'h00, 1'b0, 1'b0);
    send_frame(8'h2D, 1'b0, 1'b0, 1'b0);
    model(8'h2D, 1'b0, 1'b0, 1'b0, kind);
    check_events("rst_recover", 1, 8'h2D, 1'b0, 1'b0);

    // Random frames against the reference model
    for (int unsigned n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic bp, bs, bst;
      int r, e;
      r = $urandom_range(0, 9);
      e = $urandom_range(0, 19);
      d = (r < 2) ? 8'hF0 : (r == 2) ? 8'hE0 : 8'($urandom);
      bp  = (e < 2);
      bst = (e == 2);
      bs  = (e == 3);
      send_frame(d, bp, bs, bst);
      model(d, bp, bs, bst, kind);
      check_events($sformatf("rnd%0d_%02h", n, d), kind, m_code, m_isb, m_ise);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
